s64x7_bus_arbiter: RTL and testbench
====================================

Name: s64x7_bus_arbiter

Overview:
Two-master, one-slave arbiter for the S64X7 64-bit Wishbone-style bus (adr[63:3], sel[7:0], vpa). Master 0 is the S64X7 core, covering both instruction fetch and data load/store. Master 1 is a secondary requester such as DMA or a video fetcher. The block sits between the masters and the shared memory/IO fabric, holds bus ownership for the whole of a CYC, and routes ACK/data back to the current owner only.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin between masters; 1 = fixed priority, master 0 always wins a tie.
TIMEOUT_CYCLES, 16, cycles an unacknowledged strobe may stall before abort (only used with the optional feature); legal range 2..255.

Ports:
clk_i  in  1  bus clock.
reset_i  in  1  asynchronous, active-high reset.
m0_adr_i  in  61  master 0 address [63:3].
m0_cyc_i, m0_stb_i, m0_we_i, m0_vpa_i  in  1 each  master 0 cycle, strobe, write enable, instruction-fetch flag.
m0_sel_i  in  8  master 0 byte lane selects.
m0_dat_i  in  64  master 0 write data.
m0_ack_o  out  1  acknowledge to master 0.
m0_err_o  out  1  error/abort to master 0.
m1_adr_i, m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_dat_i  in  61/1/1/1/8/64  master 1 equivalents; master 1 has no vpa input.
m1_ack_o, m1_err_o  out  1 each  acknowledge and error to master 1.
mdat_o  out  64  read data, driven to both masters.
s_adr_o  out  61  slave address.
s_cyc_o, s_stb_o, s_we_o, s_vpa_o  out  1 each  slave cycle, strobe, write enable, fetch flag.
s_sel_o  out  8  slave byte lane selects.
s_dat_o  out  64  slave write data.
s_ack_i  in  1  slave acknowledge.
s_dat_i  in  64  slave read data.
gnt_o  out  2  one-hot current owner; 00 when idle.

Behaviour:
- States: IDLE, OWN0, OWN1. Registered state plus a last_owner bit.
- Reset (asynchronous, takes effect immediately, including mid-cycle):
  - State goes to IDLE and last_owner to 1, so master 0 wins the first tie.
  - gnt_o=00; s_cyc_o=s_stb_o=s_we_o=s_vpa_o=0; s_sel_o=0; s_adr_o=0; s_dat_o=0.
  - All ack/err outputs are 0.
- IDLE transitions, evaluated on the rising edge using cyc_i only:
  - Only m0 requests -> OWN0; only m1 requests -> OWN1.
  - Both request with PRIORITY_MODE=1 -> OWN0.
  - Both request with PRIORITY_MODE=0 -> the master that is not last_owner.
  - Grant latency from IDLE is one cycle; the first slave strobe appears the cycle after cyc_i rises.
- OWNn:
  - Slave outputs mirror master n combinationally.
  - s_vpa_o = m0_vpa_i in OWN0 and 0 in OWN1.
  - mn_ack_o = s_ack_i; the other master's ack_o = 0.
  - mdat_o = s_dat_i at all times.
  - Ownership persists while mn_cyc_i=1, across any number of beats, so LIT/load/fetch sequences are never split.
- Release:
  - In the cycle where mn_cyc_i=0, slave outputs already drop to 0, because they are combinational from the owner.
  - If the other master has cyc_i=1 -> move directly to OWNother with no dead cycle in between.
  - Otherwise -> IDLE.
  - last_owner := n on release.
- Non-owner requests are ignored: they stall, receive no ack, and see no slave strobe.
- s_ack_i arriving while IDLE is discarded.
- An owner dropping stb_i but keeping cyc_i keeps its grant, and s_stb_o=0 during that time.

Optional Feature:
S64X7_ARB_TIMEOUT_EN defined:
- An 8-bit counter increments each cycle that s_cyc_o & s_stb_o & ~s_ack_i holds, and clears on ack, release, or reset.
- When the counter reaches TIMEOUT_CYCLES-1:
  - mn_err_o pulses 1 for one cycle.
  - s_cyc_o/s_stb_o are forced to 0 in that cycle.
  - The arbiter returns to IDLE with last_owner := n.
  - The master must drop cyc_i; a still-high cyc_i is re-arbitrated as a fresh request.

S64X7_ARB_TIMEOUT_EN undefined: no counter is built, both err_o outputs are tied to 0, and stalls are unbounded.

Test Plan:
1. Reset with both cyc_i=1 -> gnt_o=00 and s_cyc_o=0 during reset. After reset_i falls: one edge later gnt_o=01, s_adr_o=m0_adr_i=61'h1C00_0000_0000_0000 (byte address E000_0000_0000_0000), s_vpa_o=1.
2. m0 holds cyc_i for 3 beats (ack each cycle) while m1 requests -> m1_ack_o=0 throughout. On the cycle m0_cyc_i falls, gnt_o switches to 10 at the next edge with no IDLE cycle. m1 write of 64'h41414141_41414141, sel 8'b00000010, is passed through.
3. PRIORITY_MODE=0 with both masters requesting continuously and single-beat cycles -> gnt_o alternates 01,10,01,10. PRIORITY_MODE=1 with the same stimulus -> 01 on every grant from IDLE.
4. m1 read from address 32'h55555550 with s_dat_i=64'h81000000_00000000 -> mdat_o equals that value, m1_ack_o=1, m0_ack_o=0, s_vpa_o=0.
5. Assert reset_i mid-beat while in OWN1 -> all s_* outputs and ack outputs go to 0 without waiting for a clock edge. After release, a simultaneous request from both masters grants m0 first.
6. With S64X7_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, m0 strobes with no ack -> m0_err_o=1 on the 16th stalled cycle, s_cyc_o=0 that cycle, gnt_o=00 afterwards. Without the macro -> no err after 100 stalled cycles.

Source files
------------

// File: rtl/s64x7_bus_arbiter.sv
// s64x7_bus_arbiter: two-master / one-slave arbiter for the S64X7 64-bit
// Wishbone-style bus. Master 0 is the core, master 1 a secondary requester.
// Ownership is held for the whole CYC. Slave-side signals are combinational
// from the current owner.
// Optional stall timeout: define S64X7_ARB_TIMEOUT_EN to build it.
module s64x7_bus_arbiter #(
    parameter int PRIORITY_MODE  = 0,   // 0 = round-robin, 1 = master 0 wins ties
    parameter int TIMEOUT_CYCLES = 16   // 2..255, used only with the timeout
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [60:0] m0_adr_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic        m0_vpa_i,
    input  logic [7:0]  m0_sel_i,
    input  logic [63:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [60:0] m1_adr_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [7:0]  m1_sel_i,
    input  logic [63:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [63:0] mdat_o,
    output logic [60:0] s_adr_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic        s_vpa_o,
    output logic [7:0]  s_sel_o,
    output logic [63:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [63:0] s_dat_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;   // last owner; 1 after reset so master 0 wins the first tie
    logic   own0, own1;       // current owner (masked by reset so outputs drop at once)
    logic   act0, act1;       // owner still holding its CYC
    logic   tmo;              // stall timeout fires this cycle

    assign own0 = (state_q == OWN0) & ~reset_i;
    assign own1 = (state_q == OWN1) & ~reset_i;
    assign act0 = own0 & m0_cyc_i;
    assign act1 = own1 & m1_cyc_i;

`ifdef S64X7_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       stall;

    assign stall = ((act0 & m0_stb_i) | (act1 & m1_stb_i)) & ~s_ack_i;
    assign tmo   = stall & (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    // Stall counter: clears on ack, release/idle or timeout, counts stalled strobes
    always_comb begin
        cnt_d = cnt_q;
        if (tmo || s_ack_i || !(act0 || act1)) cnt_d = 8'd0;
        else if (stall)                        cnt_d = cnt_q + 8'd1;
    end

    // Stall counter register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign tmo            = 1'b0;
`endif

    // Next-state: arbitrate from IDLE on cyc only; hand over directly on release
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_d = (PRIORITY_MODE == 1 || last_q) ? OWN0 : OWN1;
                else if (m0_cyc_i) state_d = OWN0;
                else if (m1_cyc_i) state_d = OWN1;
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? OWN1 : IDLE;
                end else if (tmo) begin
                    last_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? OWN0 : IDLE;
                end else if (tmo) begin
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and last-owner registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Slave mux: mirror the owner while its CYC is high; a timeout kills cyc/stb
    always_comb begin
        s_adr_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_vpa_o = 1'b0;
        s_sel_o = '0;
        s_dat_o = '0;
        if (act0) begin
            s_adr_o = m0_adr_i;
            s_cyc_o = ~tmo;
            s_stb_o = m0_stb_i & ~tmo;
            s_we_o  = m0_we_i;
            s_vpa_o = m0_vpa_i;
            s_sel_o = m0_sel_i;
            s_dat_o = m0_dat_i;
        end else if (act1) begin
            s_adr_o = m1_adr_i;
            s_cyc_o = ~tmo;
            s_stb_o = m1_stb_i & ~tmo;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_ack_o = own0 & s_ack_i;
    assign m1_ack_o = own1 & s_ack_i;
    assign m0_err_o = own0 & tmo;
    assign m1_err_o = own1 & tmo;
    assign mdat_o   = s_dat_i;
    assign gnt_o    = {own1, own0};

endmodule

// File: tb/tb_s64x7_bus_arbiter.sv
// Directed bench for s64x7_bus_arbiter: per-cycle vector table on a
// round-robin instance plus hand sequences for reset, priority and timeout.
module tb_s64x7_bus_arbiter;

    localparam logic [60:0] A0 = 61'h1C00_0000_0000_0000;
    localparam logic [60:0] A1 = 61'h0AAA_AAAA;           // 32'h55555550 >> 3
    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'h4141_4141_4141_4141;
    localparam logic [7:0]  S0 = 8'hFF;
    localparam logic [7:0]  S1 = 8'b0000_0010;
    localparam logic [63:0] SD = 64'h8100_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    logic c0, s0, w0, v0, c1, s1, w1, ack;

    logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, s_vpa;
    logic [63:0] mdat, s_dat;
    logic [60:0] s_adr;
    logic [7:0]  s_sel;
    logic [1:0]  gnt;

    logic        unused_a0, unused_e0, unused_a1, unused_e1;
    logic        unused_cyc, unused_stb, unused_we, unused_vpa;
    logic [63:0] unused_mdat, unused_sdat;
    logic [60:0] unused_adr;
    logic [7:0]  unused_sel;
    logic [1:0]  p1_gnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    s64x7_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .reset_i(rst),
        .m0_adr_i(A0), .m0_cyc_i(c0), .m0_stb_i(s0), .m0_we_i(w0), .m0_vpa_i(v0),
        .m0_sel_i(S0), .m0_dat_i(D0), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(A1), .m1_cyc_i(c1), .m1_stb_i(s1), .m1_we_i(w1),
        .m1_sel_i(S1), .m1_dat_i(D1), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .mdat_o(mdat), .s_adr_o(s_adr), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
        .s_we_o(s_we), .s_vpa_o(s_vpa), .s_sel_o(s_sel), .s_dat_o(s_dat),
        .s_ack_i(ack), .s_dat_i(SD), .gnt_o(gnt)
    );

    s64x7_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(16)) dut_p1 (
        .clk_i(clk), .reset_i(rst),
        .m0_adr_i(A0), .m0_cyc_i(c0), .m0_stb_i(s0), .m0_we_i(w0), .m0_vpa_i(v0),
        .m0_sel_i(S0), .m0_dat_i(D0), .m0_ack_o(unused_a0), .m0_err_o(unused_e0),
        .m1_adr_i(A1), .m1_cyc_i(c1), .m1_stb_i(s1), .m1_we_i(w1),
        .m1_sel_i(S1), .m1_dat_i(D1), .m1_ack_o(unused_a1), .m1_err_o(unused_e1),
        .mdat_o(unused_mdat), .s_adr_o(unused_adr), .s_cyc_o(unused_cyc),
        .s_stb_o(unused_stb), .s_we_o(unused_we), .s_vpa_o(unused_vpa),
        .s_sel_o(unused_sel), .s_dat_o(unused_sdat),
        .s_ack_i(ack), .s_dat_i(SD), .gnt_o(p1_gnt)
    );

    typedef struct {
        logic       c0, s0, v0, c1, s1, w1, ack;
        logic [1:0] gnt;
        logic       scyc, sstb, swe, svpa, a0, a1;
    } vec_t;

    vec_t tv[17];

    function automatic vec_t mk(input logic [6:0] in, input logic [1:0] g, input logic [5:0] ex);
        vec_t v;
        {v.c0, v.s0, v.v0, v.c1, v.s1, v.w1, v.ack} = in;
        v.gnt = g;
        {v.scyc, v.sstb, v.swe, v.svpa, v.a0, v.a1} = ex;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic v, input logic c,
                         input logic d, input logic w, input logic k);
        c0 = a; s0 = b; v0 = v; c1 = c; s1 = d; w1 = w; ack = k;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [60:0] ea;
        logic [63:0] ed;
        logic [7:0]  es;
        logic [1:0]  rr_exp [3];
        logic        err_seen;

        //               c0 s0 v0 c1 s1 w1 ack   gnt     scyc sstb swe svpa a0 a1
        tv[0]  = mk(7'b1111110, 2'b00, 6'b000000);
        tv[1]  = mk(7'b1111111, 2'b01, 6'b110111 & 6'b110110);
        tv[2]  = tv[1];
        tv[3]  = tv[1];
        tv[4]  = mk(7'b0001110, 2'b01, 6'b000000);
        tv[5]  = mk(7'b0001111, 2'b10, 6'b111001);
        tv[6]  = mk(7'b0000000, 2'b10, 6'b000000);
        tv[7]  = mk(7'b0000001, 2'b00, 6'b000000);
        tv[8]  = mk(7'b1111100, 2'b00, 6'b000000);
        tv[9]  = mk(7'b1111101, 2'b01, 6'b110110);
        tv[10] = mk(7'b0001100, 2'b01, 6'b000000);
        tv[11] = mk(7'b1111101, 2'b10, 6'b110001);
        tv[12] = mk(7'b1110000, 2'b10, 6'b000000);
        tv[13] = mk(7'b1111101, 2'b01, 6'b110110);
        tv[14] = mk(7'b0001100, 2'b01, 6'b000000);
        tv[15] = mk(7'b1111000, 2'b10, 6'b100000);
        tv[16] = mk(7'b1111101, 2'b10, 6'b110001);

        w0 = 1'b0;
        rst = 1'b1;
        drive(1, 1, 1, 1, 1, 0, 0);

        // Reset held with both masters requesting: nothing granted
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'(2'b00));
        chk("rst_scyc", 64'(s_cyc), 64'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_idle_gnt", 64'(gnt), 64'(2'b00));
        @(posedge clk);
        #1;
        chk("first_gnt", 64'(gnt), 64'(2'b01));
        chk("first_adr", 64'(s_adr), 64'(A0));
        chk("first_vpa", 64'(s_vpa), 64'(1'b1));

        // Vector table on the round-robin instance
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i != 0) @(negedge clk);
            drive(tv[i].c0, tv[i].s0, tv[i].v0, tv[i].c1, tv[i].s1, tv[i].w1, tv[i].ack);
            #1;
            ea = !tv[i].scyc ? 61'h0 : (tv[i].gnt == 2'b01 ? A0 : A1);
            ed = !tv[i].scyc ? 64'h0 : (tv[i].gnt == 2'b01 ? D0 : D1);
            es = !tv[i].scyc ? 8'h0  : (tv[i].gnt == 2'b01 ? S0 : S1);
            chk($sformatf("v%0d_gnt", i),  64'(gnt),   64'(tv[i].gnt));
            chk($sformatf("v%0d_scyc", i), 64'(s_cyc), 64'(tv[i].scyc));
            chk($sformatf("v%0d_sstb", i), 64'(s_stb), 64'(tv[i].sstb));
            chk($sformatf("v%0d_swe", i),  64'(s_we),  64'(tv[i].swe));
            chk($sformatf("v%0d_svpa", i), 64'(s_vpa), 64'(tv[i].svpa));
            chk($sformatf("v%0d_ack0", i), 64'(m0_ack), 64'(tv[i].a0));
            chk($sformatf("v%0d_ack1", i), 64'(m1_ack), 64'(tv[i].a1));
            chk($sformatf("v%0d_adr", i),  64'(s_adr), 64'(ea));
            chk($sformatf("v%0d_dat", i),  s_dat,      ed);
            chk($sformatf("v%0d_sel", i),  64'(s_sel), 64'(es));
            chk($sformatf("v%0d_mdat", i), mdat,       SD);
            chk($sformatf("v%0d_err", i),  64'({m0_err, m1_err}), 64'(2'b00));
        end

        // Reset asserted mid-beat while master 1 owns the bus
        @(negedge clk);
        drive(1, 1, 1, 1, 1, 0, 1);
        #1 chk("mid_pre_ack1", 64'(m1_ack), 64'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("mid_gnt", 64'(gnt), 64'(2'b00));
        chk("mid_scyc", 64'({s_cyc, s_stb, s_we, s_vpa}), 64'(4'b0));
        chk("mid_ack", 64'({m0_ack, m1_ack}), 64'(2'b00));
        chk("mid_adr", 64'(s_adr), 64'(0));
        chk("mid_dat", s_dat, 64'(0));
        chk("mid_sel", 64'(s_sel), 64'(0));
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("mid_after_gnt", 64'(gnt), 64'(2'b01));

        // Grants from IDLE with both requesting: alternate vs fixed priority
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            drive(1, 1, 0, 1, 1, 0, 0);
            @(negedge clk);
            drive(1, 1, 0, 1, 1, 0, 1);
            #1;
            chk($sformatf("rr%0d_gnt", r), 64'(gnt), 64'(rr_exp[r]));
            chk($sformatf("fp%0d_gnt", r), 64'(p1_gnt), 64'(2'b01));
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end

        // Master 0 strobes with no slave ack
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0);
        err_seen = 1'b0;
`ifdef S64X7_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            if (k < 16) err_seen = err_seen | m0_err;
        end
        chk("tmo_early_err", 64'(err_seen), 64'(1'b0));
        chk("tmo_err", 64'(m0_err), 64'(1'b1));
        chk("tmo_scyc", 64'(s_cyc), 64'(1'b0));
        @(negedge clk);
        #1;
        chk("tmo_gnt_after", 64'(gnt), 64'(2'b00));
        chk("tmo_err_after", 64'(m0_err), 64'(1'b0));
`else
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            #1 err_seen = err_seen | m0_err | m1_err;
        end
        chk("stall_no_err", 64'(err_seen), 64'(1'b0));
        chk("stall_gnt", 64'(gnt), 64'(2'b01));
        chk("stall_scyc", 64'(s_cyc), 64'(1'b1));
`endif
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
